key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 19 +
 rtl/sync2.sv | 22 ++
 rtl/key_debounce.sv | 104 ++++++++++
 tb/tb_key_debounce.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and parameter arithmetic for the push-button debouncer.
`timescale 1ns/1ps
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_t;

  // Converts a time amount into clk cycles; unit_div is cycles-per-unit divisor (1e6 for us, 1e3 for ms).
  function automatic int cycles_for(input int clk_hz, input int unit_div, input int amount);
    int n;
    n = clk_hz / unit_div * amount;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous active-low input; idles high.
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes key_n, qualifies press/release, and flags long holds.
`timescale 1ns/1ps
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_US   = 10,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_n,
  output logic key_level,
  output logic press,
  // release is a reserved word, so the release pulse carries a suffix
  output logic release_pulse,
  output logic long_press,
  output logic toggle
);

  localparam int DB_CYCLES = cycles_for(CLK_FREQ_HZ, 1_000_000, DEBOUNCE_US);
  localparam int LP_CYCLES = cycles_for(CLK_FREQ_HZ, 1_000, LONG_PRESS_MS);
  localparam int DB_W      = $clog2(DB_CYCLES) + 1;
  localparam int LP_W      = $clog2(LP_CYCLES) + 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYCLES);

  logic            key_s;
  db_state_t       state;
  logic [DB_W-1:0] db_cnt;
  logic [LP_W-1:0] hold_cnt;

  sync2 u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (key_n),
    .q    (key_s)
  );

  // The debounce counter counts the extra stable cycles after the first
  // differing sample, so an accepted edge needs DB_CYCLES further samples.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      key_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        RELEASED: begin
          if (!key_s) begin
            state  <= WAIT_PRESS;
            db_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (key_s) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state     <= PRESSED;
            press     <= 1'b1;
            toggle    <= ~toggle;
            key_level <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state  <= WAIT_RELEASE;
            db_cnt <= '0;
          end else if (hold_cnt != LP_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == LP_LAST) long_press <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          // A bounce back to pressed resumes the hold count where it stopped.
          if (!key_s) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed and randomized bench for key_debounce against a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int CLK_HZ = 5_000_000;   // 200 ns period keeps long holds short in cycles
  localparam int DB     = 50;          // 5 MHz * 10 us
  localparam int LP     = 5000;        // 5 MHz * 1 ms
  localparam int LAT    = 2 + DB + 1;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic key_n = 1'b1;
  logic key_level, press, release_pulse, long_press, toggle;

  int compared = 0;
  int mismatched = 0;

  key_debounce #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .DEBOUNCE_US   (10),
    .LONG_PRESS_MS (1)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .key_n         (key_n),
    .key_level     (key_level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .toggle        (toggle)
  );

  always #100 clk = ~clk;

  // Reference: key_s is key_n delayed two edges; an edge is accepted when the
  // sampled level has held for DB+1 consecutive samples; hold time counts
  // back-to-back low samples after the press.
  typedef struct {
    logic s1, s2, prev_s, run_val, pressed, press, rel, lng, tog;
    int   run, hold;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.s1 = 1'b1; r.s2 = 1'b1; r.prev_s = 1'b1; r.run_val = 1'b1;
    r.pressed = 1'b0; r.press = 1'b0; r.rel = 1'b0; r.lng = 1'b0; r.tog = 1'b0;
    r.run = 0; r.hold = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input logic kn);
    model_t n;
    logic ks;
    n = c;
    ks = c.s2;
    n.s2 = c.s1;
    n.s1 = kn;
    n.press = 1'b0; n.rel = 1'b0; n.lng = 1'b0;
    if (ks == c.run_val) n.run = c.run + 1;
    else begin
      n.run_val = ks;
      n.run = 1;
    end
    if (!c.pressed && !ks && n.run == DB + 1) begin
      n.pressed = 1'b1; n.press = 1'b1; n.tog = ~c.tog; n.hold = 0;
    end else if (c.pressed && ks && n.run == DB + 1) begin
      n.pressed = 1'b0; n.rel = 1'b1;
    end else if (c.pressed && !ks && !c.prev_s && c.hold < LP) begin
      n.hold = c.hold + 1;
      n.lng = (n.hold == LP);
    end
    n.prev_s = ks;
    return n;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) m <= model_reset();
    else       m <= model_step(m, key_n);
  end

  // Event monitor for pulse counts, toggle transitions and press/release ordering.
  int   n_press = 0, n_rel = 0, n_long = 0, n_tog = 0, n_order_err = 0;
  logic prev_tog = 1'b0;
  logic last_press = 1'b0;

  always @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_tog   <= 1'b0;
      last_press <= 1'b0;
    end else begin
      n_press     <= n_press + int'(press);
      n_rel       <= n_rel + int'(release_pulse);
      n_long      <= n_long + int'(long_press);
      n_tog       <= n_tog + int'(toggle != prev_tog);
      prev_tog    <= toggle;
      n_order_err <= n_order_err + int'((press && last_press) || (release_pulse && !last_press)
                                        || (press && release_pulse) || (long_press && release_pulse));
      last_press  <= press ? 1'b1 : (release_pulse ? 1'b0 : last_press);
    end
  end

  task automatic check_model(input string tag);
    logic [4:0] obs, exp;
    obs = {key_level, press, release_pulse, long_press, toggle};
    exp = {m.pressed, m.press, m.rel, m.lng, m.tog};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s t=%0t outputs{lvl,prs,rel,lp,tog} observed=%b expected=%b", tag, $time, obs, exp);
      $error("model mismatch %s", tag);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      $error("value mismatch %s", tag);
    end
  endtask

  task automatic expect_bits(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      $error("value mismatch %s", tag);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_model(tag);
    end
  endtask

  // Returns the number of edges until the chosen pulse appears, 0 if the bound expires.
  task automatic wait_pulse(input string tag, input logic want_release, output int lat);
    lat = 0;
    for (int i = 1; i <= 4 * LAT; i++) begin
      @(posedge clk);
      #1;
      check_model(tag);
      if ((want_release ? release_pulse : press) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #(50_000_000);
    $display("FAIL watchdog t=%0t observed=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int p0, r0, l0, t0, o0;
    int total;
    int len;
    logic lvl;

    // Reset state
    #5 nrst = 1'b0;
    #1 expect_bits("reset_outputs", {key_level, press, release_pulse, long_press, toggle}, 5'b0);
    repeat (3) @(posedge clk);
    #50 nrst = 1'b1;
    run(5, "idle");

    // Clean press and release, latency from the key_n edge
    key_n = 1'b0;
    wait_pulse("clean_press", 1'b0, lat);
    expect_int("clean_press_latency", lat, LAT);
    #2 expect_bits("clean_pressed_state", {key_level, toggle, 3'b000}, 5'b11000);
    run(40, "clean_hold");
    key_n = 1'b1;
    wait_pulse("clean_release", 1'b1, lat);
    expect_int("clean_release_latency", lat, LAT);
    run(20, "clean_idle");

    // Bounce before settling low: one press, timed from the last edge
    p0 = n_press;
    key_n = 1'b0; run(2, "bounce");
    key_n = 1'b1; run(1, "bounce");
    key_n = 1'b0;
    wait_pulse("bounce_press", 1'b0, lat);
    expect_int("bounce_latency", lat, LAT);
    run(30, "bounce_hold");
    expect_int("bounce_press_count", n_press - p0, 1);
    key_n = 1'b1; run(80, "bounce_release");

    // Short glitch must not register
    p0 = n_press;
    key_n = 1'b0; #256; key_n = 1'b1;
    run(80, "glitch");
    expect_int("glitch_press_count", n_press - p0, 0);
    expect_bits("glitch_state", {key_level, toggle, 3'b000}, 5'b00000);

    // Boundary: DB low samples rejected, DB+1 accepted
    p0 = n_press; r0 = n_rel;
    key_n = 1'b0; run(DB, "boundary_short");
    key_n = 1'b1; run(80, "boundary_short");
    expect_int("boundary_short_press", n_press - p0, 0);
    key_n = 1'b0; run(DB + 1, "boundary_exact");
    key_n = 1'b1; run(80, "boundary_exact");
    expect_int("boundary_exact_press", n_press - p0, 1);
    expect_int("boundary_exact_release", n_rel - r0, 1);

    // Long press: one long pulse, none again on release
    l0 = n_long; r0 = n_rel;
    key_n = 1'b0; run(7500, "long_hold");
    expect_int("long_count_held", n_long - l0, 1);
    key_n = 1'b1; run(100, "long_release");
    expect_int("long_count_after_release", n_long - l0, 1);
    expect_int("long_release_count", n_rel - r0, 1);

    // Reset while pressed: immediate clear, no release pulse afterwards
    key_n = 1'b0; run(80, "midreset_press");
    expect_bits("midreset_before", {key_level, toggle, 3'b000}, 5'b11000);
    r0 = n_rel;
    #30 nrst = 1'b0;
    #1 expect_bits("midreset_async_clear", {key_level, press, release_pulse, long_press, toggle}, 5'b0);
    repeat (2) @(posedge clk);
    #30 nrst = 1'b1;
    run(LAT + 10, "midreset_requalify");
    expect_int("midreset_no_release", n_rel - r0, 0);
    expect_bits("midreset_requalified", {key_level, toggle, 3'b000}, 5'b11000);
    key_n = 1'b1; run(80, "midreset_release");
    expect_int("midreset_final_release", n_rel - r0, 1);

    // Random bounce sequence scoreboard
    @(posedge clk);
    #30 nrst = 1'b0;
    #40 nrst = 1'b1;
    p0 = n_press; r0 = n_rel; t0 = n_tog; o0 = n_order_err;
    total = 0;
    lvl = 1'b1;
    while (total < 20000) begin
      lvl = ~lvl;
      if ($urandom_range(3, 0) == 0) len = $urandom_range(600, 60);
      else len = $urandom_range(40, 1);
      key_n = lvl;
      run(len, "random");
      total += len;
    end
    key_n = 1'b1; run(100, "random_tail");
    expect_int("random_press_vs_toggle", n_press - p0, n_tog - t0);
    expect_int("random_press_vs_release", n_press - p0, n_rel - r0);
    expect_int("random_order_errors", n_order_err - o0, 0);
    expect_int("random_any_press", int'((n_press - p0) > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
